stark_fpu_rs_queue: RTL and testbench
=====================================

Name: stark_fpu_rs_queue

Overview:
Multi-entry, parametrised FPU reservation station that replaces the single-slot station.
- Accepts one dispatched FP op per cycle from the ROB/dispatch stage into any free entry.
- Captures source operands from NBYP register-file/bypass snoop ports, including the dispatch cycle.
- Issues the oldest ready op to the FPU with a valid/ready handshake.
- Supports checkpoint-mask flush on branch mispredict.

Parameters:
NENT, 4, number of entries (2..16)
NARG, 4, operands per entry (A,B,C,T)
NBYP, 16, snoop/bypass ports
DW, 64, operand value width
PRW, 9, physical register number width; preg 0 reads as zero
IDW, 5, ROB index width
NCP, 16, checkpoint count; cp field width = clog2(NCP)
PLW, 128, opaque payload width (instr, pc, Rt, aRt, imm, qfext, cptgt), carried unmodified

Ports:
clk  in  1  clock
rst  in  1  reset
disp_v  in  1  dispatch request
disp_rdy  out  1  at least one free entry
disp_id  in  IDW  ROB index
disp_cp  in  clog2(NCP)  checkpoint index
disp_prs  in  NARG*PRW  source pregs
disp_pl  in  PLW  payload
byp_prn  in  NBYP*PRW  snoop preg numbers
byp_v  in  NBYP  snoop valids
byp_val  in  NBYP*DW  snoop values
byp_tag  in  NBYP  snoop tag bits
iss_v  out  1  issue valid
iss_rdy  in  1  FPU accepts
iss_id  out  IDW  issued ROB index
iss_cp  out  clog2(NCP)  issued checkpoint
iss_arg  out  NARG*DW  operand values
iss_tag  out  NARG  operand tags
iss_pl  out  PLW  issued payload
flush_v  in  1  flush request
flush_mask  in  NCP  checkpoints to kill
occ  out  clog2(NENT+1)  occupied entry count

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. All entries invalid, all operand-valid bits 0, age matrix 0, occ=0, disp_rdy=1, iss_v=0. iss_id/iss_cp/iss_arg/iss_tag/iss_pl = 0. Reset asserted mid-operation discards all entries in the next cycle.
- Entry state: FREE -> WAIT (some operand invalid) -> READY (all NARG operands valid, registered) -> FREE on issue or flush.
- Dispatch:
  - Accepted when disp_v && disp_rdy.
  - Writes the lowest-index entry that is FREE per registered state. An entry freed in the current cycle is not reusable until the next cycle.
  - disp_rdy depends only on registered state, never on iss_rdy.
- Dispatch operand capture:
  - Operand with prs==0: value 0, tag 0, valid.
  - Otherwise, if any byp port matches (byp_v && byp_prn==prs), capture the value/tag and set valid.
  - If several ports match, the highest port index wins.
- Snoop: every WAIT operand compares against all NBYP ports each cycle. A match captures the value/tag and sets valid; already-valid operands are never overwritten.
- Readiness is registered: an entry whose last operand is captured at edge N is eligible for issue from cycle N onward. The minimum dispatch-to-issue latency is 1 cycle, when all operands are resolved at dispatch.
- Age: NENT x NENT age matrix. On dispatch, the new entry is marked younger than all currently valid entries. Issue selects the READY entry with no older READY entry.
- Issue:
  - iss_v = any eligible entry. Outputs are a combinational mux of the selected entry.
  - Entry is freed at the edge where iss_v && iss_rdy.
  - While iss_rdy=0, the selection may change only if an older entry becomes ready or the selected entry is flushed.
- Flush:
  - When flush_v, entries with flush_mask[cp]=1 become FREE at the edge and are excluded from selection in the same cycle, so iss_v drops if only killed entries were ready.
  - A dispatch in the flush cycle whose disp_cp is masked is dropped.
  - Flush takes priority over issue and snoop capture.
- occ: registered count = valid entries. Updated per edge by +dispatch, -issue, -flushed, with no underflow or overflow. When full, disp_rdy=0 and disp_v is ignored.
- Simultaneous dispatch and issue in the same cycle when full: issue frees an entry, dispatch stalls (disp_rdy was 0).

Test Plan:
- Reset then dispatch id=3 with all prs=0 -> iss_v=1 next cycle, iss_arg all 0, iss_id=3; with iss_rdy=1, occ returns 1->0.
- Dispatch id=5 with prs A=12 unresolved; two cycles later byp port2 {prn=12, val=0x4000_0000_0000_0000} -> iss_v rises the cycle after capture with argA=0x4000_0000_0000_0000.
- Dispatch id 1,2,3 pending, then resolve in order 3,1,2 on the same cycle -> issue order 1,2,3 with iss_rdy=1.
- Fill NENT=4 entries -> disp_rdy=0, occ=4; issue one -> disp_rdy=1 next cycle, occ=3.
- Entries with cp 2,3,2 plus flush_v with mask=0x0004 -> both cp=2 entries freed, occ 3->1, only the cp=3 entry remains issuable; a same-cycle dispatch with cp=2 is dropped.
- Ports 1 and 7 both match prs=20 with values 0x11 and 0x77 -> captured value 0x77; a later match with value 0x99 does not overwrite it.

Source files
------------

// File: rtl/stark_fpu_rs_queue.sv
// Multi-entry FPU reservation station.
// Entries are allocated lowest-free-first, capture their source operands from
// the bypass/snoop ports (including on the dispatch cycle), and the oldest
// fully-resolved entry is presented to the FPU through a valid/ready handshake.
// A checkpoint-mask flush frees every entry whose checkpoint is killed.
module stark_fpu_rs_queue #(
    parameter int NENT = 4,
    parameter int NARG = 4,
    parameter int NBYP = 16,
    parameter int DW   = 64,
    parameter int PRW  = 9,
    parameter int IDW  = 5,
    parameter int NCP  = 16,
    parameter int PLW  = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_v,
    output logic                       disp_rdy,
    input  logic [IDW-1:0]             disp_id,
    input  logic [$clog2(NCP)-1:0]     disp_cp,
    input  logic [NARG*PRW-1:0]        disp_prs,
    input  logic [PLW-1:0]             disp_pl,
    input  logic [NBYP*PRW-1:0]        byp_prn,
    input  logic [NBYP-1:0]            byp_v,
    input  logic [NBYP*DW-1:0]         byp_val,
    input  logic [NBYP-1:0]            byp_tag,
    output logic                       iss_v,
    input  logic                       iss_rdy,
    output logic [IDW-1:0]             iss_id,
    output logic [$clog2(NCP)-1:0]     iss_cp,
    output logic [NARG*DW-1:0]         iss_arg,
    output logic [NARG-1:0]            iss_tag,
    output logic [PLW-1:0]             iss_pl,
    input  logic                       flush_v,
    input  logic [NCP-1:0]             flush_mask,
    output logic [$clog2(NENT+1)-1:0]  occ
);

    localparam int CPW = $clog2(NCP);
    localparam int EIW = $clog2(NENT);
    localparam int OCW = $clog2(NENT+1);

    typedef struct packed {
        logic          hit;
        logic          tag;
        logic [DW-1:0] val;
    } cap_t;

    // Control state (reset)
    logic [NENT-1:0] vld_q, vld_d;
    logic [NARG-1:0] opv_q [NENT];
    logic [NARG-1:0] opv_d [NENT];
    // age_q[i][j] = 1 means entry j is older than entry i
    logic [NENT-1:0] age_q [NENT];
    logic [NENT-1:0] age_d [NENT];
    logic [OCW-1:0]  occ_q, occ_d;

    // Data state (no reset; qualified by the control bits)
    logic [DW-1:0]   val_q [NENT][NARG];
    logic [DW-1:0]   val_d [NENT][NARG];
    logic [NARG-1:0] tag_q [NENT];
    logic [NARG-1:0] tag_d [NENT];
    logic [PRW-1:0]  prs_q [NENT][NARG];
    logic [IDW-1:0]  id_q  [NENT];
    logic [CPW-1:0]  cp_q  [NENT];
    logic [PLW-1:0]  pl_q  [NENT];

    logic [NENT-1:0] kill;
    logic [NENT-1:0] elig;
    logic [NENT-1:0] sel_oh;
    logic [EIW-1:0]  alloc_idx;
    logic            alloc_found;
    logic            disp_acc;
    logic            iss_fire;

    // Look up a physical register on the bypass ports; preg 0 is a constant zero
    // and the highest-numbered matching port wins.
    function automatic cap_t byp_lookup(
        input logic [PRW-1:0]      prs,
        input logic [NBYP-1:0]     bv,
        input logic [NBYP*PRW-1:0] bprn,
        input logic [NBYP*DW-1:0]  bval,
        input logic [NBYP-1:0]     btag
    );
        cap_t c;
        c = '0;
        if (prs == '0) begin
            c.hit = 1'b1;
        end else begin
            for (int p = 0; p < NBYP; p++) begin
                if (bv[p] && (bprn[p*PRW +: PRW] == prs)) begin
                    c.hit = 1'b1;
                    c.tag = btag[p];
                    c.val = bval[p*DW +: DW];
                end
            end
        end
        return c;
    endfunction

    // Lowest-index free entry, judged on registered state only
    always_comb begin
        alloc_idx   = '0;
        alloc_found = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (!vld_q[i] && !alloc_found) begin
                alloc_idx   = EIW'(i);
                alloc_found = 1'b1;
            end
        end
    end

    assign disp_rdy = ~(&vld_q);
    assign disp_acc = disp_v && disp_rdy && !(flush_v && flush_mask[disp_cp]);

    // Entries killed by this cycle's flush
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            kill[i] = flush_v && vld_q[i] && flush_mask[cp_q[i]];
        end
    end

    // Issue candidates: valid, all operands captured, and not being flushed
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            elig[i] = vld_q[i] && (&opv_q[i]) && !kill[i];
        end
    end

    // Oldest candidate: no other candidate is older than it
    always_comb begin
        for (int i = 0; i < NENT; i++) begin
            sel_oh[i] = elig[i] && ((elig & age_q[i]) == '0);
        end
    end

    assign iss_v    = |sel_oh;
    assign iss_fire = iss_v && iss_rdy;

    // Issue output mux; all-zero when nothing is selected
    always_comb begin
        iss_id  = '0;
        iss_cp  = '0;
        iss_arg = '0;
        iss_tag = '0;
        iss_pl  = '0;
        for (int i = 0; i < NENT; i++) begin
            if (sel_oh[i]) begin
                iss_id  = iss_id | id_q[i];
                iss_cp  = iss_cp | cp_q[i];
                iss_pl  = iss_pl | pl_q[i];
                iss_tag = iss_tag | tag_q[i];
                for (int a = 0; a < NARG; a++) begin
                    iss_arg[a*DW +: DW] = iss_arg[a*DW +: DW] | val_q[i][a];
                end
            end
        end
    end

    // Next state: snoop capture, issue/flush release, dispatch allocation
    always_comb begin
        cap_t c;
        vld_d = vld_q;
        opv_d = opv_q;
        age_d = age_q;
        val_d = val_q;
        tag_d = tag_q;
        c     = '0;
        for (int i = 0; i < NENT; i++) begin
            for (int a = 0; a < NARG; a++) begin
                if (vld_q[i] && !opv_q[i][a]) begin
                    c = byp_lookup(prs_q[i][a], byp_v, byp_prn, byp_val, byp_tag);
                    if (c.hit) begin
                        opv_d[i][a] = 1'b1;
                        val_d[i][a] = c.val;
                        tag_d[i][a] = c.tag;
                    end
                end
            end
            if ((iss_fire && sel_oh[i]) || kill[i]) begin
                vld_d[i] = 1'b0;
            end
        end
        if (disp_acc) begin
            vld_d[alloc_idx] = 1'b1;
            age_d[alloc_idx] = vld_q;
            for (int j = 0; j < NENT; j++) begin
                age_d[j][alloc_idx] = 1'b0;
            end
            for (int a = 0; a < NARG; a++) begin
                c = byp_lookup(disp_prs[a*PRW +: PRW], byp_v, byp_prn, byp_val, byp_tag);
                opv_d[alloc_idx][a] = c.hit;
                val_d[alloc_idx][a] = c.val;
                tag_d[alloc_idx][a] = c.tag;
            end
        end
    end

    // Occupancy is the population count of the next valid vector
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < NENT; i++) begin
            occ_d = occ_d + {{(OCW-1){1'b0}}, vld_d[i]};
        end
    end

    assign occ = occ_q;

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < NENT; i++) begin
                opv_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
            opv_q <= opv_d;
            age_q <= age_d;
        end
    end

    // Data registers: operand values every cycle, dispatch fields on allocation
    always_ff @(posedge clk) begin
        val_q <= val_d;
        tag_q <= tag_d;
        if (disp_acc) begin
            id_q[alloc_idx] <= disp_id;
            cp_q[alloc_idx] <= disp_cp;
            pl_q[alloc_idx] <= disp_pl;
            for (int a = 0; a < NARG; a++) begin
                prs_q[alloc_idx][a] <= disp_prs[a*PRW +: PRW];
            end
        end
    end

endmodule

// File: tb/tb_stark_fpu_rs_queue.sv
// Directed, table-driven bench for stark_fpu_rs_queue (default parameters).
module tb_stark_fpu_rs_queue;

    localparam int NENT = 4, NARG = 4, NBYP = 16, DW = 64, PRW = 9;
    localparam int IDW = 5, NCP = 16, PLW = 128;
    localparam int NV = 46;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  disp_v;
    logic                  disp_rdy;
    logic [IDW-1:0]        disp_id;
    logic [3:0]            disp_cp;
    logic [NARG*PRW-1:0]   disp_prs;
    logic [PLW-1:0]        disp_pl;
    logic [NBYP*PRW-1:0]   byp_prn;
    logic [NBYP-1:0]       byp_v;
    logic [NBYP*DW-1:0]    byp_val;
    logic [NBYP-1:0]       byp_tag;
    logic                  iss_v;
    logic                  iss_rdy;
    logic [IDW-1:0]        iss_id;
    logic [3:0]            iss_cp;
    logic [NARG*DW-1:0]    iss_arg;
    logic [NARG-1:0]       iss_tag;
    logic [PLW-1:0]        iss_pl;
    logic                  flush_v;
    logic [NCP-1:0]        flush_mask;
    logic [2:0]            occ;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stark_fpu_rs_queue #(
        .NENT(NENT), .NARG(NARG), .NBYP(NBYP), .DW(DW), .PRW(PRW),
        .IDW(IDW), .NCP(NCP), .PLW(PLW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_v(disp_v), .disp_rdy(disp_rdy), .disp_id(disp_id), .disp_cp(disp_cp),
        .disp_prs(disp_prs), .disp_pl(disp_pl),
        .byp_prn(byp_prn), .byp_v(byp_v), .byp_val(byp_val), .byp_tag(byp_tag),
        .iss_v(iss_v), .iss_rdy(iss_rdy), .iss_id(iss_id), .iss_cp(iss_cp),
        .iss_arg(iss_arg), .iss_tag(iss_tag), .iss_pl(iss_pl),
        .flush_v(flush_v), .flush_mask(flush_mask), .occ(occ)
    );

    typedef struct packed {
        logic             dv;
        logic [4:0]       id;
        logic [3:0]       cp;
        logic [8:0]       prsa;
        logic [2:0]       ben;
        logic [2:0][3:0]  bport;
        logic [2:0][8:0]  bprn;
        logic [2:0][63:0] bval;
        logic [2:0]       btag;
        logic             rdy;
        logic             fv;
        logic [15:0]      fmask;
        logic             ev;
        logic [4:0]       eid;
        logic [63:0]      earg;
        logic             etag;
        logic             edrdy;
        logic [2:0]       eocc;
    } vec_t;

    vec_t tbl [NV];

    function automatic vec_t mk(input int dv, input int id, input int cp, input int prsa,
                                input int rdy, input int fv, input int fmask,
                                input int ev, input int eid, input logic [63:0] earg,
                                input int etag, input int edrdy, input int eocc);
        vec_t v;
        v       = '0;
        v.dv    = 1'(dv);
        v.id    = 5'(id);
        v.cp    = 4'(cp);
        v.prsa  = 9'(prsa);
        v.rdy   = 1'(rdy);
        v.fv    = 1'(fv);
        v.fmask = 16'(fmask);
        v.ev    = 1'(ev);
        v.eid   = 5'(eid);
        v.earg  = earg;
        v.etag  = 1'(etag);
        v.edrdy = 1'(edrdy);
        v.eocc  = 3'(eocc);
        return v;
    endfunction

    function automatic vec_t addb(input vec_t vi, input int s, input int port, input int prn,
                                  input logic [63:0] val, input int tag);
        vec_t v;
        v          = vi;
        v.ben[s]   = 1'b1;
        v.bport[s] = 4'(port);
        v.bprn[s]  = 9'(prn);
        v.bval[s]  = val;
        v.btag[s]  = 1'(tag);
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        disp_v     = 1'b0;
        disp_id    = '0;
        disp_cp    = '0;
        disp_prs   = '0;
        disp_pl    = '0;
        byp_v      = '0;
        byp_prn    = '0;
        byp_val    = '0;
        byp_tag    = '0;
        iss_rdy    = 1'b0;
        flush_v    = 1'b0;
        flush_mask = '0;
    endtask

    task automatic apply(input vec_t v);
        int p;
        drive_idle();
        disp_v     = v.dv;
        disp_id    = v.id;
        disp_cp    = v.cp;
        disp_prs   = {27'b0, v.prsa};
        disp_pl    = {123'b0, v.id};
        iss_rdy    = v.rdy;
        flush_v    = v.fv;
        flush_mask = v.fmask;
        for (int s = 0; s < 3; s++) begin
            if (v.ben[s]) begin
                p = int'(v.bport[s]);
                byp_v[p]               = 1'b1;
                byp_tag[p]             = v.btag[s];
                byp_prn[p*PRW +: PRW]  = v.bprn[s];
                byp_val[p*DW +: DW]    = v.bval[s];
            end
        end
    endtask

    task automatic check_row(input int r, input vec_t v);
        chk("iss_v", r, 256'(iss_v), 256'(v.ev));
        chk("disp_rdy", r, 256'(disp_rdy), 256'(v.edrdy));
        chk("occ", r, 256'(occ), 256'(v.eocc));
        if (v.ev) begin
            chk("iss_id", r, 256'(iss_id), 256'(v.eid));
            chk("iss_arg", r, 256'(iss_arg), {192'b0, v.earg});
            chk("iss_tag", r, 256'(iss_tag), 256'({3'b0, v.etag}));
        end
    endtask

    initial begin
        // dispatch with all-zero sources, issue next cycle
        tbl[0]  = mk(1, 3, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0,  1, 0, 0,  1, 3, 0, 0, 1, 1);
        tbl[2]  = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 0);
        // operand A resolved by snoop two cycles after dispatch
        tbl[3]  = mk(1, 5, 0, 12, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[5]  = addb(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1), 0, 2, 12, 64'h4000_0000_0000_0000, 0);
        tbl[6]  = mk(0, 0, 0, 0,  1, 0, 0,  1, 5, 64'h4000_0000_0000_0000, 0, 1, 1);
        // three waiters resolved together, issued oldest first
        tbl[7]  = mk(1, 1, 0, 21, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(1, 2, 0, 22, 1, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[9]  = mk(1, 3, 0, 23, 1, 0, 0,  0, 0, 0, 0, 1, 2);
        tbl[10] = addb(addb(addb(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3),
                       0, 0, 23, 64'h33, 0), 1, 1, 21, 64'h11, 0), 2, 2, 22, 64'h22, 0);
        tbl[11] = mk(0, 0, 0, 0,  1, 0, 0,  1, 1, 64'h11, 0, 1, 3);
        tbl[12] = mk(0, 0, 0, 0,  1, 0, 0,  1, 2, 64'h22, 0, 1, 2);
        tbl[13] = mk(0, 0, 0, 0,  1, 0, 0,  1, 3, 64'h33, 0, 1, 1);
        // fill, full stall, issue while full
        tbl[14] = mk(1, 8, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[15] = mk(1, 9, 0, 0,  0, 0, 0,  1, 8, 0, 0, 1, 1);
        tbl[16] = mk(1, 10, 0, 0, 0, 0, 0,  1, 8, 0, 0, 1, 2);
        tbl[17] = mk(1, 11, 0, 0, 0, 0, 0,  1, 8, 0, 0, 1, 3);
        tbl[18] = mk(1, 12, 0, 0, 0, 0, 0,  1, 8, 0, 0, 0, 4);
        tbl[19] = mk(1, 13, 0, 0, 1, 0, 0,  1, 8, 0, 0, 0, 4);
        tbl[20] = mk(0, 0, 0, 0,  0, 0, 0,  1, 9, 0, 0, 1, 3);
        tbl[21] = mk(0, 0, 0, 0,  1, 0, 0,  1, 9, 0, 0, 1, 3);
        tbl[22] = mk(0, 0, 0, 0,  1, 0, 0,  1, 10, 0, 0, 1, 2);
        tbl[23] = mk(0, 0, 0, 0,  1, 0, 0,  1, 11, 0, 0, 1, 1);
        // checkpoint flush with same-cycle masked dispatch
        tbl[24] = mk(1, 20, 2, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[25] = mk(1, 21, 3, 0, 0, 0, 0,  1, 20, 0, 0, 1, 1);
        tbl[26] = mk(1, 22, 2, 0, 0, 0, 0,  1, 20, 0, 0, 1, 2);
        tbl[27] = mk(1, 23, 2, 0, 0, 1, 16'h0004,  1, 21, 0, 0, 1, 3);
        tbl[28] = mk(0, 0, 0, 0,  1, 0, 0,  1, 21, 0, 0, 1, 1);
        // flush of the only ready entry drops iss_v in the same cycle
        tbl[29] = mk(1, 24, 5, 0, 1, 0, 0,  0, 0, 0, 0, 1, 0);
        tbl[30] = mk(0, 0, 0, 0,  1, 1, 16'h0020,  0, 0, 0, 0, 1, 1);
        // bypass port priority at dispatch, no overwrite afterwards
        tbl[31] = addb(addb(mk(1, 25, 0, 20, 0, 0, 0, 0, 0, 0, 0, 1, 0),
                       0, 1, 20, 64'h11, 0), 1, 7, 20, 64'h77, 1);
        tbl[32] = addb(mk(0, 0, 0, 0, 0, 0, 0, 1, 25, 64'h77, 1, 1, 1), 0, 3, 20, 64'h99, 0);
        tbl[33] = mk(0, 0, 0, 0,  1, 0, 0,  1, 25, 64'h77, 1, 1, 1);
        // bypass port priority on the snoop path
        tbl[34] = mk(1, 26, 0, 40, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[35] = addb(addb(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),
                       0, 1, 40, 64'h11, 0), 1, 7, 40, 64'h77, 1);
        tbl[36] = addb(mk(0, 0, 0, 0, 0, 0, 0, 1, 26, 64'h77, 1, 1, 1), 0, 3, 40, 64'h99, 0);
        tbl[37] = mk(0, 0, 0, 0,  1, 0, 0,  1, 26, 64'h77, 1, 1, 1);
        tbl[38] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 0);
        // older entry becoming ready displaces a stalled younger selection
        tbl[39] = mk(1, 14, 0, 50, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[40] = mk(1, 15, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1);
        tbl[41] = mk(0, 0, 0, 0,  0, 0, 0,  1, 15, 0, 0, 1, 2);
        tbl[42] = addb(mk(0, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0, 1, 2), 0, 5, 50, 64'h5, 1);
        tbl[43] = mk(0, 0, 0, 0,  1, 0, 0,  1, 14, 64'h5, 1, 1, 2);
        tbl[44] = mk(0, 0, 0, 0,  1, 0, 0,  1, 15, 0, 0, 1, 1);
        tbl[45] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 1, 0);

        // reset state
        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_iss_v", -1, 256'(iss_v), 256'(0));
        chk("rst_occ", -1, 256'(occ), 256'(0));
        chk("rst_disp_rdy", -1, 256'(disp_rdy), 256'(1));
        chk("rst_iss_id", -1, 256'(iss_id), 256'(0));
        chk("rst_iss_cp", -1, 256'(iss_cp), 256'(0));
        chk("rst_iss_arg", -1, 256'(iss_arg), 256'(0));
        chk("rst_iss_tag", -1, 256'(iss_tag), 256'(0));
        chk("rst_iss_pl", -1, 256'(iss_pl), 256'(0));
        @(posedge clk);
        #1;

        for (int r = 0; r < NV; r++) begin
            apply(tbl[r]);
            @(negedge clk);
            check_row(r, tbl[r]);
            @(posedge clk);
            #1;
        end

        // payload and checkpoint are carried to the issue port
        drive_idle();
        disp_v  = 1'b1;
        disp_id = 5'd7;
        disp_cp = 4'd9;
        disp_pl = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        chk("pl_iss_v", 100, 256'(iss_v), 256'(1));
        chk("pl_iss_id", 100, 256'(iss_id), 256'(7));
        chk("pl_iss_cp", 100, 256'(iss_cp), 256'(9));
        chk("pl_iss_pl", 100, 256'(iss_pl), 256'(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210));
        chk("pl_iss_tag", 100, 256'(iss_tag), 256'(0));

        // reset in the middle of operation discards everything
        disp_v  = 1'b1;
        disp_id = 5'd4;
        disp_cp = 4'd1;
        @(posedge clk);
        #1 drive_idle();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_occ_before", 101, 256'(occ), 256'(2));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_occ", 102, 256'(occ), 256'(0));
        chk("mid_iss_v", 102, 256'(iss_v), 256'(0));
        chk("mid_disp_rdy", 102, 256'(disp_rdy), 256'(1));
        chk("mid_iss_pl", 102, 256'(iss_pl), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
